serial_subtractor8b: RTL and testbench
======================================

// Module: serial_subtractor8b
// PURPOSE
//  Bit-serial subtractor: computes d = a - b - bin, LSB first, one bit per clock.
//  Inverse datapath partner of fulladder8b (recovers an operand from a sum).
//  Trades area for latency with one full-subtractor cell reused WIDTH times.
//  Start/ready/done handshake toward a controlling FSM or testbench.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
// PORTS
//  clk    in   1      rising-edge clock
//  rst    in   1      reset, asynchronous, active-high
//  start  in   1      request; sampled only when ready=1
//  a      in   WIDTH  minuend, captured on accepted start
//  b      in   WIDTH  subtrahend, captured on accepted start
//  bin    in   1      borrow-in, captured on accepted start
//  ready  out  1      1 = IDLE, start will be accepted
//  busy   out  1      1 = SHIFT in progress
//  done   out  1      one-cycle pulse: d/bout/ovf valid
//  d      out  WIDTH  difference, registered, held until next completion
//  bout   out  1      borrow-out (1 = unsigned a < b+bin)
//  ovf    out  1      signed two's-complement overflow of a-b-bin
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, cnt=0, borrow=0, shift regs=0,
//   d=0, bout=0, ovf=0, done=0, busy=0, ready=1. In-flight operation discarded.
//  FSM states: IDLE, SHIFT, DONE.
//   IDLE:  start=1 at edge -> latch a,b into shift regs, borrow<=bin, cnt<=0, ->SHIFT.
//          start=0 -> stay.
//   SHIFT: each edge: diff_bit = a_sh[0]^b_sh[0]^borrow;
//          borrow <= (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&borrow);
//          res_sh <= {diff_bit, res_sh[WIDTH-1:1]}; a_sh,b_sh >> 1; cnt++.
//          On edge where cnt==WIDTH-1: also d<=final result, bout<=new borrow,
//          ovf<=(a_msb^b_msb)&(a_msb^diff_msb) from latched MSBs, ->DONE.
//   DONE:  done=1 for exactly this cycle; next edge ->IDLE unconditionally.
//  Latency: start accepted at edge k -> done high in cycle after edge k+WIDTH
//   (WIDTH+1 cycles start-to-done); next start accepted at edge k+WIDTH+2 earliest.
//  start while busy or in DONE: ignored, no queueing, no effect on result.
//  a/b/bin may change freely after the accepting edge.
//  d/bout/ovf change only at completion edge or reset; never mid-SHIFT.
//  ready=(state==IDLE), busy=(state==SHIFT), done=(state==DONE): decoded from state reg.
//  Arithmetic modulo 2^WIDTH; cnt width = $clog2(WIDTH), no wrap past WIDTH-1.
// STRUCTURE
//  Shared package/header: state encodings (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2).
//  Sub-module: fullsubtractor1b (x,y,bin -> diff,bout), combinational, one instance
//   in the bit-serial loop; borrow flip-flop lives in this module.
//  No other hierarchy; single always block for state/counter/regs, async rst.
// TESTING
//  1 a=8'd5, b=8'd3, bin=0, start 1 cycle -> done at +9 cycles, d=8'd2, bout=0, ovf=0.
//  2 a=8'h00, b=8'h01, bin=0 -> d=8'hFF, bout=1, ovf=0.
//  3 a=8'h80, b=8'h01, bin=0 -> d=8'h7F, bout=0, ovf=1; a=8'h00,b=8'h00,bin=1 -> d=8'hFF,bout=1.
//  4 start a=8'd10,b=8'd4; assert start again with a=8'd1,b=8'd1 at cycle 3 ->
//    ignored, result d=8'd6, ready low throughout SHIFT, exactly one done pulse.
//  5 rst pulsed at cycle 4 of an operation (a=8'hF0,b=8'h0F) -> immediately
//    ready=1, busy=0, d=0, no done pulse; a fresh start then completes correctly.
//  6 Exhaustive a,b in 0..15 x bin in {0,1}, back-to-back starts -> d/bout match
//    reference model {bout,d} = a - b - bin for every case.

Source files
------------

// File: rtl/serial_subtractor8b_pkg.sv
// rtl/serial_subtractor8b_pkg.sv - shared state encodings for the bit-serial subtractor
package serial_subtractor8b_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/serial_subtractor8b_fullsubtractor1b.sv
// rtl/serial_subtractor8b_fullsubtractor1b.sv - combinational one-bit full subtractor cell
module fullsubtractor1b (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor8b.sv
// rtl/serial_subtractor8b.sv - bit-serial a-b-bin, LSB first, start/ready/done handshake
module serial_subtractor8b
  import serial_subtractor8b_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             a_msb;
  logic             b_msb;
  logic             fs_diff;
  logic             fs_bout;
  logic [WIDTH-1:0] res_next;

  fullsubtractor1b u_cell (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (borrow),
    .diff (fs_diff),
    .bout (fs_bout)
  );

  assign res_next = {fs_diff, res_sh[WIDTH-1:1]};

  assign ready = (state == ST_IDLE);
  assign busy  = (state == ST_SHIFT);
  assign done  = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      borrow <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      d      <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            borrow <= bin;
            cnt    <= '0;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          borrow <= fs_bout;
          res_sh <= res_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          // Last bit: publish the result; the counter parks at LAST.
          if (cnt == LAST) begin
            d     <= res_next;
            bout  <= fs_bout;
            ovf   <= (a_msb ^ b_msb) & (a_msb ^ fs_diff);
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor8b.sv
// tb/tb_serial_subtractor8b.sv - randomized and directed checks against an arithmetic model
module tb_serial_subtractor8b;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;

  int vectors = 0;
  int errors  = 0;

  logic [W-1:0] last_d    = '0;
  logic         last_bout = 1'b0;
  logic         last_ovf  = 1'b0;

  serial_subtractor8b #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Runs one operation from IDLE; inject > 0 raises a spurious start at that SHIFT cycle.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       input int inject);
    logic [W:0] ed;
    int         r;
    logic       eovf;
    int         n;
    bit         seen;
    ed   = {1'b0, ia} - {1'b0, ib} - {{W{1'b0}}, ibin};
    r    = int'($signed(ia)) - int'($signed(ib)) - int'(ibin);
    eovf = (r < -(2 ** (W - 1))) || (r > (2 ** (W - 1)) - 1);

    vectors++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_start got=%b exp=1", ready);
    end
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);

    n = 1;
    seen = 0;
    while (n <= 3 * W) begin
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      vectors++;
      if (busy !== 1'b1 || ready !== 1'b0 || d !== last_d || bout !== last_bout || ovf !== last_ovf) begin
        errors++;
        $display("FAIL shift_status cyc=%0d busy=%b ready=%b d=%h bout=%b ovf=%b exp busy=1 ready=0 d=%h bout=%b ovf=%b",
                 n, busy, ready, d, bout, ovf, last_d, last_bout, last_ovf);
      end
      if (n == inject) begin
        start = 1'b1; a = W'(1); b = W'(1); bin = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;

    vectors++;
    if (!seen || n != W + 1) begin
      errors++;
      $display("FAIL latency seen=%0d cycles=%0d exp=%0d", seen, n, W + 1);
    end
    vectors++;
    if (d !== ed[W-1:0] || bout !== ed[W] || ovf !== eovf) begin
      errors++;
      $display("FAIL result a=%h b=%h bin=%b got d=%h bout=%b ovf=%b exp d=%h bout=%b ovf=%b",
               ia, ib, ibin, d, bout, ovf, ed[W-1:0], ed[W], eovf);
    end
    vectors++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL done_status busy=%b ready=%b exp 0 0", busy, ready);
    end
    last_d = ed[W-1:0]; last_bout = ed[W]; last_ovf = eovf;

    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || ready !== 1'b1 || d !== last_d) begin
      errors++;
      $display("FAIL after_done done=%b ready=%b d=%h exp 0 1 %h", done, ready, d, last_d);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || d !== '0 || bout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state ready=%b busy=%b done=%b d=%h bout=%b ovf=%b exp 1 0 0 00 0 0",
               ready, busy, done, d, bout, ovf);
    end
  endtask

  task automatic test_directed();
    do_op(8'd5, 8'd3, 1'b0, -1);
    do_op(8'h00, 8'h01, 1'b0, -1);
    do_op(8'h80, 8'h01, 1'b0, -1);
    do_op(8'h00, 8'h00, 1'b1, -1);
    do_op(8'h7F, 8'hFF, 1'b0, -1);
    do_op(8'hFF, 8'hFF, 1'b1, -1);
  endtask

  task automatic test_ignored_start();
    do_op(8'd10, 8'd4, 1'b0, 3);
  endtask

  task automatic test_reset_midop();
    a = 8'hF0; b = 8'h0F; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || d !== '0 || bout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset ready=%b busy=%b done=%b d=%h bout=%b ovf=%b exp 1 0 0 00 0 0",
               ready, busy, done, d, bout, ovf);
    end
    last_d = '0; last_bout = 1'b0; last_ovf = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || ready !== 1'b1) begin
        errors++;
        $display("FAIL no_done_after_reset cyc=%0d done=%b ready=%b exp 0 1", i, done, ready);
      end
    end
    do_op(8'hF0, 8'h0F, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), -1);
    end
  endtask

  task automatic test_back_to_back();
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int bi = 0; bi < 2; bi++) begin
          do_op(W'(ia), W'(ib), 1'(bi), -1);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #2;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    test_directed();
    test_ignored_start();
    test_reset_midop();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
